// File: rtl/channel_vector_broadcaster_if.sv
// Stream bundle for the channel vector broadcaster: a serial channel-value
// input stream and a broadcast feature-map output stream, both valid/ready.
interface channel_vector_broadcaster_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 160,
  parameter int OUT_HEIGHT = 7,
  parameter int OUT_WIDTH  = 7
);
  localparam int CW = (CHANNELS   > 1) ? $clog2(CHANNELS)   : 1;
  localparam int HW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int WW = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;

  // Input vector stream
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  // Output feature-map stream
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_first;
  logic                  out_last;
  logic [CW-1:0]         out_c;
  logic [HW-1:0]         out_h;
  logic [WW-1:0]         out_w;

  // Sticky framing status
  logic                  len_err;

  // Producer of the vector / consumer of the map
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last,
    input  out_c, out_h, out_w, len_err
  );

  // The broadcaster itself
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last,
    output out_c, out_h, out_w, len_err
  );
endinterface

// File: rtl/channel_vector_broadcaster.sv
// Channel vector broadcaster: buffers one CHANNELS-long vector arriving
// serially, then replays it OUT_HEIGHT*OUT_WIDTH times pixel-major (channel
// index fastest), i.e. a 1x1 -> HxW nearest-neighbour unpooling.
module channel_vector_broadcaster #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 160,
  parameter int OUT_HEIGHT = 7,
  parameter int OUT_WIDTH  = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  channel_vector_broadcaster_if.slave bus
);

  localparam int CW = (CHANNELS   > 1) ? $clog2(CHANNELS)   : 1;
  localparam int HW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int WW = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;

  localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);
  localparam logic [HW-1:0] H_MAX = HW'(OUT_HEIGHT - 1);
  localparam logic [WW-1:0] W_MAX = WW'(OUT_WIDTH - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         c_q, c_d;
  logic [HW-1:0]         h_q, h_d;
  logic [WW-1:0]         w_q, w_d;
  logic                  len_err_q, len_err_d;

  // Single vector buffer; never reset, contents are always overwritten
  // by a complete load before they are replayed.
  logic [DATA_WIDTH-1:0] mem_q [CHANNELS];

  logic in_fire;
  logic out_fire;
  logic emit_act;
  logic wr_last;
  logic c_end;
  logic w_end;
  logic h_end;
  logic beat_last;

  // Handshake qualification and counter terminal conditions
  always_comb begin
    emit_act  = (state_q == ST_EMIT) && !rst;
    in_fire   = (state_q == ST_LOAD) && !rst && bus.in_valid;
    out_fire  = emit_act && bus.out_ready;
    wr_last   = (wr_cnt_q == C_MAX);
    c_end     = (c_q == C_MAX);
    w_end     = (w_q == W_MAX);
    h_end     = (h_q == H_MAX);
    beat_last = c_end && w_end && h_end;
  end

  // Next-state: load counter, broadcast counters, framing check, FSM
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    c_d       = c_q;
    h_d       = h_q;
    w_d       = w_q;
    len_err_d = len_err_q;

    if (in_fire) begin
      // Vector length is defined by the beat count; in_last only audits it.
      if (bus.in_last != wr_last) begin
        len_err_d = 1'b1;
      end
      if (wr_last) begin
        wr_cnt_d = '0;
        state_d  = ST_EMIT;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    if (out_fire) begin
      if (c_end) begin
        c_d = '0;
        if (w_end) begin
          w_d = '0;
          h_d = h_end ? '0 : h_q + HW'(1);
        end else begin
          w_d = w_q + WW'(1);
        end
      end else begin
        c_d = c_q + CW'(1);
      end
      if (beat_last) begin
        state_d = ST_LOAD;
      end
    end
  end

  // Output stream: driven straight from state and counters so everything
  // holds while out_ready is low; reset forces a quiet bus.
  always_comb begin
    bus.in_ready  = (state_q == ST_LOAD) && !rst;
    bus.out_valid = emit_act;
    bus.out_data  = rst ? '0 : mem_q[c_q];
    bus.out_c     = rst ? '0 : c_q;
    bus.out_h     = rst ? '0 : h_q;
    bus.out_w     = rst ? '0 : w_q;
    bus.out_first = emit_act && (c_q == '0) && (h_q == '0) && (w_q == '0);
    bus.out_last  = emit_act && beat_last;
    bus.len_err   = len_err_q && !rst;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      wr_cnt_q  <= '0;
      c_q       <= '0;
      h_q       <= '0;
      w_q       <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      c_q       <= c_d;
      h_q       <= h_d;
      w_q       <= w_d;
      len_err_q <= len_err_d;
    end
  end

  // Vector buffer write on each accepted input beat
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_cnt_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_channel_vector_broadcaster.sv
// Scoreboard bench for channel_vector_broadcaster: a default-size instance
// driven through directed scenarios and a 3x2x2 instance checked against a
// hand-written beat table.
module tb_channel_vector_broadcaster;

  localparam int DW = 16;
  localparam int C  = 160;
  localparam int H  = 7;
  localparam int W  = 7;
  localparam int N  = C * H * W;
  localparam int SC = 3;
  localparam int SH = 2;
  localparam int SW = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
    logic [2:0]  h;
    logic [2:0]  w;
    logic        f;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  always #5 clk = ~clk;

  channel_vector_broadcaster_if #(.DATA_WIDTH(DW), .CHANNELS(C), .OUT_HEIGHT(H), .OUT_WIDTH(W)) m_bus ();
  channel_vector_broadcaster_if #(.DATA_WIDTH(DW), .CHANNELS(SC), .OUT_HEIGHT(SH), .OUT_WIDTH(SW)) s_bus ();

  channel_vector_broadcaster #(.DATA_WIDTH(DW), .CHANNELS(C), .OUT_HEIGHT(H), .OUT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_bus)
  );

  channel_vector_broadcaster #(.DATA_WIDTH(DW), .CHANNELS(SC), .OUT_HEIGHT(SH), .OUT_WIDTH(SW)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (s_bus)
  );

  beat_t exp_q[$];
  beat_t sexp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    beats_seen = 0;
  bit    thr_out = 1'b0;
  bit    small_done = 1'b0;
  bit    hold = 1'b0;
  bit    inr_next = 1'b0;
  beat_t held;
  beat_t e_m;
  beat_t e_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t m_cur();
    beat_t b;
    b.d = m_bus.out_data;
    b.c = 8'(m_bus.out_c);
    b.h = 3'(m_bus.out_h);
    b.w = 3'(m_bus.out_w);
    b.f = m_bus.out_first;
    b.l = m_bus.out_last;
    return b;
  endfunction

  function automatic beat_t s_cur();
    beat_t b;
    b.d = s_bus.out_data;
    b.c = 8'(s_bus.out_c);
    b.h = 3'(s_bus.out_h);
    b.w = 3'(s_bus.out_w);
    b.f = s_bus.out_first;
    b.l = s_bus.out_last;
    return b;
  endfunction

  // Downstream throttle for the main instance
  always @(posedge clk) begin
    #1;
    m_bus.out_ready = thr_out ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Main monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (rst) begin
      hold     = 1'b0;
      inr_next = 1'b0;
    end else begin
      if (inr_next) begin
        check("in_ready_after_last", 32'(m_bus.in_ready), 32'd1);
      end
      inr_next = 1'b0;
      if (hold) begin
        check("stall_valid", 32'(m_bus.out_valid), 32'd1);
        check("stall_hold", m_cur(), held);
      end
      if (m_bus.out_valid) begin
        check("no_input_in_emit", 32'(m_bus.in_ready), 32'd0);
      end
      if (m_bus.out_valid && m_bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected none", m_cur());
        end else begin
          e_m = exp_q.pop_front();
          check("beat", m_cur(), e_m);
        end
        beats_seen++;
        if (m_bus.out_last) inr_next = 1'b1;
      end
      hold = m_bus.out_valid && !m_bus.out_ready;
      held = m_cur();
    end
  end

  // Small-instance monitor
  always @(negedge clk) begin
    if (!rst_s && s_bus.out_valid && s_bus.out_ready) begin
      if (sexp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL small_unexpected_beat: got %h expected none", s_cur());
      end else begin
        e_s = sexp_q.pop_front();
        check("small_beat", s_cur(), e_s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_bus.in_valid = 1'b0;
    m_bus.in_last  = 1'b0;
    exp_q.delete();
    beats_seen = 0;
    tick();
    @(negedge clk);
    check("rst_in_ready", 32'(m_bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(m_bus.out_valid), 32'd0);
    check("rst_first_last", {30'd0, m_bus.out_first, m_bus.out_last}, 32'd0);
    check("rst_out_fields", {m_bus.out_data, 8'(m_bus.out_c), 4'(m_bus.out_h), 4'(m_bus.out_w)}, 32'd0);
    check("rst_len_err", 32'(m_bus.len_err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(m_bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(m_bus.out_valid), 32'd0);
    check("post_rst_len_err", 32'(m_bus.len_err), 32'd0);
    tick();
  endtask

  task automatic push_map(input logic [15:0] base);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.c = 8'(k % C);
      b.w = 3'((k / C) % W);
      b.h = 3'(k / (C * W));
      b.d = base + 16'(k % C);
      b.f = (k == 0);
      b.l = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // Feed beats base+i; stop_after < C abandons the vector part-way
  task automatic load_vec(input logic [15:0] base, input int last_pos, input bit thr_in, input int stop_after);
    int budget;
    for (int i = 0; i < stop_after; i++) begin
      if (thr_in) begin
        while ($urandom_range(0, 1) == 0) begin
          m_bus.in_valid = 1'b0;
          tick();
        end
      end
      m_bus.in_data  = base + 16'(i);
      m_bus.in_last  = (i == last_pos);
      m_bus.in_valid = 1'b1;
      budget = 0;
      forever begin
        @(negedge clk);
        if (m_bus.in_ready) break;
        budget++;
        if (budget > 40000) begin
          $display("FAIL in_accept_timeout: beat %0d never accepted", i);
          $fatal(1, "input stalled");
        end
        tick();
      end
      tick();
    end
    m_bus.in_valid = 1'b0;
    m_bus.in_last  = 1'b0;
    if (stop_after == C) begin
      push_map(base);
      @(negedge clk);
      check("first_valid_latency", 32'(m_bus.out_valid), 32'd1);
      tick();
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0) begin
      tick();
      b++;
      if (b > 40000) begin
        $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
        $fatal(1, "output stalled");
      end
    end
  endtask

  task automatic wait_beats(input int n);
    int b = 0;
    while (beats_seen < n) begin
      tick();
      b++;
      if (b > 40000) begin
        $display("FAIL beats_timeout: saw %0d of %0d", beats_seen, n);
        $fatal(1, "output stalled");
      end
    end
  endtask

  // Small 3x2x2 configuration against a hand-written beat table
  initial begin
    logic [15:0] sv [SC] = '{16'h00A0, 16'h00B1, 16'h00C2};
    int sh [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int sw [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int scc[12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
    beat_t b;
    int budget;
    rst_s = 1'b1;
    s_bus.in_valid  = 1'b0;
    s_bus.in_data   = '0;
    s_bus.in_last   = 1'b0;
    s_bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b0;
    for (int k = 0; k < 12; k++) begin
      b.d = sv[scc[k]];
      b.c = 8'(scc[k]);
      b.h = 3'(sh[k]);
      b.w = 3'(sw[k]);
      b.f = (k == 0);
      b.l = (k == 11);
      sexp_q.push_back(b);
    end
    for (int i = 0; i < SC; i++) begin
      s_bus.in_data  = sv[i];
      s_bus.in_last  = (i == SC - 1);
      s_bus.in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    s_bus.in_valid = 1'b0;
    s_bus.in_last  = 1'b0;
    budget = 0;
    while (sexp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("small_beats_left", 32'(sexp_q.size()), 32'd0);
    check("small_len_err", 32'(s_bus.len_err), 32'd0);
    small_done = 1'b1;
  end

  // Main scenario sequence
  initial begin
    int b;
    rst = 1'b1;
    m_bus.in_valid  = 1'b0;
    m_bus.in_data   = '0;
    m_bus.in_last   = 1'b0;
    m_bus.out_ready = 1'b1;
    do_reset();

    // Plain vector, free-running output
    load_vec(16'h0100, C - 1, 1'b0, C);
    wait_drain();
    check("len_err_clean", 32'(m_bus.len_err), 32'd0);

    // Back-to-back A then B, B throttled on both sides
    load_vec(16'h1000, C - 1, 1'b0, C);
    thr_out = 1'b1;
    load_vec(16'h2000, C - 1, 1'b1, C);
    wait_drain();
    thr_out = 1'b0;
    tick();
    check("len_err_b2b", 32'(m_bus.len_err), 32'd0);

    // Early in_last on beat 50
    load_vec(16'h4000, 50, 1'b0, C);
    check("len_err_early_last", 32'(m_bus.len_err), 32'd1);
    wait_drain();
    check("len_err_sticky", 32'(m_bus.len_err), 32'd1);

    // in_last never asserted
    do_reset();
    load_vec(16'h5000, -1, 1'b0, C);
    check("len_err_no_last", 32'(m_bus.len_err), 32'd1);
    wait_drain();

    // Reset during load, then during emit
    do_reset();
    load_vec(16'h6000, C - 1, 1'b0, 80);
    do_reset();
    load_vec(16'h7000, C - 1, 1'b0, C);
    wait_beats(3000);
    do_reset();
    load_vec(16'h0800, C - 1, 1'b0, C);
    wait_drain();
    check("len_err_after_rst", 32'(m_bus.len_err), 32'd0);

    repeat (20) tick();
    b = 0;
    while (!small_done && b < 1000) begin
      tick();
      b++;
    end
    check("small_done", 32'(small_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/channel_vector_broadcaster.md
Name: channel_vector_broadcaster

Overview:
- Inverse of the spatial-to-vector flattening stage: takes a 1D per-channel vector and expands it back into a CHANNELS×OUT_HEIGHT×OUT_WIDTH feature map by nearest-neighbour broadcast (1×1 → H×W unpooling).
- Sits between the classifier/attention vector path and downstream spatial consumers.
- Channel values arrive serially on a valid/ready stream, are buffered, then re-emitted pixel-major (channel index fastest) on a second valid/ready stream.

Parameters:
- DATA_WIDTH, 16, bit width of each element.
- CHANNELS, 160, vector length and output channel count.
- OUT_HEIGHT, 7, output rows.
- OUT_WIDTH, 7, output columns.
- Derived, not overridable: CW=$clog2(CHANNELS), HW=$clog2(OUT_HEIGHT), WW=$clog2(OUT_WIDTH); each is at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  channel value.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final channel of the vector.
- in_ready  out  1  block accepts input.
- out_data  out  DATA_WIDTH  broadcast element.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_first  out  1  beat (h=0,w=0,c=0).
- out_last  out  1  beat (H-1,W-1,C-1).
- out_c  out  CW  channel index of the current beat.
- out_h  out  HW  row index.
- out_w  out  WW  column index.
- len_err  out  1  sticky framing error.

Behaviour:
- Storage: CHANNELS×DATA_WIDTH register buffer. Counters: wr_cnt (CW), and c/h/w read counters.
- FSM states: LOAD, EMIT.
- Reset, while rst=1:
  - state=LOAD; wr_cnt=c=h=w=0; len_err=0.
  - in_ready=0 and out_valid=0 are forced while rst is high.
  - out_first=out_last=0.
  - out_data, out_c, out_h, out_w = 0.
  - Buffer contents are not cleared.
- Reset mid-operation: abandons any partial load or emit. The next vector restarts at channel 0. No beat is emitted after the rst cycle.
- LOAD:
  - in_ready=1 (combinational from state), out_valid=0.
  - On in_valid&in_ready: buf[wr_cnt]<=in_data and wr_cnt++.
  - On the accept with wr_cnt==CHANNELS-1: wr_cnt<=0, state<=EMIT.
  - The beat count alone defines vector length.
  - in_last=1 on any beat other than CHANNELS-1, or in_last=0 on beat CHANNELS-1, sets len_err=1. Data is still stored and the count is unaffected.
  - len_err clears only on rst.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_data=buf[c], out_c=c, out_h=h, out_w=w.
  - out_first=(h==0&&w==0&&c==0); out_last=(h==H-1&&w==W-1&&c==C-1).
  - On out_valid&out_ready: c++. At c==C-1, c wraps to 0 and w++. At w==W-1, w wraps to 0 and h++.
  - On the out_last accept: c=h=w=0, state<=LOAD.
  - With out_ready=0, all outputs hold stable (AXI-style: no retraction, no change).
- Latency and throughput:
  - The first out_valid is asserted the cycle after the final input accept.
  - in_ready returns the cycle after the out_last accept.
  - No bubble cycles otherwise.
  - Minimum period per vector: CHANNELS + CHANNELS×OUT_HEIGHT×OUT_WIDTH cycles (7,840+160 at defaults).
- Simultaneous events: input and output never handshake in the same cycle because the buffer is single. in_valid during EMIT is ignored and stalled.
- No arithmetic on data; values pass through bit-exact.

Test Plan:
- Load values 0x0100+c for c=0..159 with in_last on c=159, out_ready=1 → 7,840 beats. Beat k has out_c=k%160, out_w=(k/160)%7, out_h=k/1120, out_data=0x0100+out_c. out_first only on beat 0, out_last only on beat 7,839, len_err=0.
- Random in_valid and out_ready throttling (~50%) → identical beat sequence. out_data and indices are held across every stall cycle. No input accepted while in EMIT.
- Back-to-back vectors A then B → in_ready=1 on the cycle after A's out_last accept. B's first out_valid is on the cycle after B's 160th accept. No A data appears in B's output.
- in_last asserted on beat 50 → len_err=1 and sticky. Load still completes after 160 beats. Separately, a 160-beat vector with in_last never asserted → len_err=1.
- rst pulsed after 80 input beats, and again mid-EMIT at beat 3,000 → out_valid=0 and in_ready=0 during rst. The next vector reloads from channel 0 and emits a full, correct 7,840-beat map. len_err=0.
- Small configuration CHANNELS=3, OUT_HEIGHT=2, OUT_WIDTH=2 → 12 beats. (h,w,c) order is (0,0,0..2), (0,1,0..2), (1,0,0..2), (1,1,0..2).
